// File: rtl/mem_pkg.sv
// Shared definitions for the word-memory request interface.
// The cache controller reuses the default latency and burst constants.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      BEAT
   } state_t;

   localparam logic [15:0] WR_ACK_DATA       = 16'h0000;
   localparam int unsigned DEFAULT_LATENCY   = 4;
   localparam int unsigned DEFAULT_MAX_BURST = 8;

   // Writes are always one beat; a read length of zero means one word.
   function automatic logic [3:0] len_eff(input logic wr, input logic [3:0] len);
      return (wr || (len == 4'd0)) ? 4'd1 : len;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port 16-bit word array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module mem_array #(
   parameter int unsigned MEM_AW = 15
) (
   input  logic              clk,
   input  logic              we,
   input  logic [MEM_AW-1:0] addr,
   input  logic [15:0]       wdata,
   output logic [15:0]       rdata
);

   logic [15:0] mem [2**MEM_AW];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, fixed access latency,
// single-word or burst read responses and write acknowledge beats.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned LATENCY   = DEFAULT_LATENCY,
   parameter int unsigned MEM_AW    = 15,
   parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic [3:0]  req_len,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        rsp_last,
   input  logic        rsp_ready,
   output logic        busy,
   output logic        err
);

   localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);
   localparam logic [4:0] MAX_B    = 5'(MAX_BURST);

   state_t      state, state_nx;
   logic [3:0]  lat_cnt;
   logic [3:0]  remaining;
   logic        cur_wr;
   logic [14:0] cur_word;   // word address; its 15-bit wrap equals the 16-bit byte-address wrap
   logic [15:0] cur_wdata;
   logic [3:0]  leff;
   logic        accept, bad, take;
   logic        mem_we;
   logic [15:0] rdata;

   assign leff   = len_eff(req_wr, req_len);
   assign accept = req_valid && (state == IDLE);
   assign bad    = req_addr[0] || (!req_wr && ({1'b0, leff} > MAX_B));
   assign take   = accept && !bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lat_cnt   <= '0;
         remaining <= '0;
         cur_wr    <= 1'b0;
         cur_word  <= '0;
         cur_wdata <= '0;
         err       <= 1'b0;
      end else begin
         state <= state_nx;
         err   <= accept && bad;
         if (take) begin
            cur_wr    <= req_wr;
            cur_word  <= req_addr[15:1];
            cur_wdata <= req_wdata;
            remaining <= leff;
            lat_cnt   <= LAT_INIT;
         end
         if ((state == WAIT) && (lat_cnt != 4'd0)) lat_cnt <= lat_cnt - 4'd1;
         if ((state == BEAT) && rsp_ready && (remaining != 4'd1)) begin
            cur_word  <= cur_word + 15'd1;
            remaining <= remaining - 4'd1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (take) state_nx = WAIT;
         WAIT:    if (lat_cnt == 4'd0) state_nx = BEAT;
         BEAT:    if (rsp_ready && (remaining == 4'd1)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      busy      = (state != IDLE);
      rsp_valid = (state == BEAT);
      rsp_last  = (state == BEAT) && (remaining == 4'd1);
      rsp_data  = '0;
      if (state == BEAT) rsp_data = cur_wr ? WR_ACK_DATA : rdata;
      mem_we    = (state == WAIT) && (lat_cnt == 4'd0) && cur_wr;
   end

   mem_array #(.MEM_AW(MEM_AW)) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (cur_word[MEM_AW-1:0]),
      .wdata (cur_wdata),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder against a word-array reference model.
module tb_mem_responder;

   localparam int unsigned LAT = 4;
   localparam int unsigned MAXB = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wr = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic [3:0]  req_len = '0;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_last;
   logic        rsp_ready = 1'b1;
   logic        busy;
   logic        err;

   mem_responder #(.LATENCY(LAT), .MEM_AW(15), .MAX_BURST(MAXB)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_len   (req_len),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_last  (rsp_last),
      .rsp_ready (rsp_ready),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        last;
      bit          first;
      int unsigned due;
   } beat_t;

   beat_t       exp_q[$];
   logic [15:0] model [int unsigned];
   int unsigned cycle = 0;
   int          checks = 0;
   int          errors = 0;
   int          rdy_mode = 0;
   int          pat = 0;
   bit          idle_chk = 0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // rsp_ready driver: 0 = always high, 1 = random, 2 = pattern 1,0,0, 3 = manual
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = 1'($urandom_range(0, 1));
            2: begin
               rsp_ready = (pat == 0);
               pat = (pat + 1) % 3;
            end
            default: ;
         endcase
      end
   end

   // Monitor: compares every presented beat with the head of the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (idle_chk) begin
            chk("req_ready_after_last", req_ready, 1);
            idle_chk = 0;
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_beat: got data %0h with no response expected", rsp_data);
            end else begin
               if (exp_q[0].first) begin
                  chk("first_beat_latency", cycle, exp_q[0].due);
                  exp_q[0].first = 0;
               end
               chk("rsp_data", rsp_data, exp_q[0].data);
               chk("rsp_last", rsp_last, exp_q[0].last);
               chk("busy_in_beat", busy, 1);
               if (rsp_ready) begin
                  if (exp_q[0].last) idle_chk = 1;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic wait_accept(output bit ok);
      bit rdy;
      int unsigned guard = 0;
      do begin
         @(negedge clk);
         rdy = req_ready;
         @(posedge clk);
         guard++;
      end while (!rdy && guard < 300);
      ok = rdy;
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready never seen within %0d cycles", guard);
      end
      #1 req_valid = 1'b0;
   endtask

   task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [3:0] len);
      bit ok;
      int unsigned n;
      bit bad;
      logic [14:0] w;
      beat_t b;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_len   = len;
      wait_accept(ok);
      if (!ok) return;
      n   = (wr || len == 0) ? 1 : int'(len);
      bad = addr[0] || (!wr && n > MAXB);
      if (bad) begin
         @(negedge clk);
         chk("reject_err_pulse", err, 1);
         chk("reject_stays_idle", busy, 0);
         @(negedge clk);
         chk("reject_err_cleared", err, 0);
      end else if (wr) begin
         model[int'(addr[15:1])] = wd;
         b = '{data: 16'h0000, last: 1'b1, first: 1, due: cycle + LAT};
         exp_q.push_back(b);
      end else begin
         for (int i = 0; i < int'(n); i++) begin
            w = addr[15:1] + 15'(i);
            b = '{data: model[int'(w)], last: (i == int'(n) - 1), first: (i == 0),
                  due: cycle + LAT};
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic drain();
      int unsigned guard = 0;
      while ((exp_q.size() != 0 || idle_chk) && guard < 1000) begin
         @(posedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d beats outstanding", exp_q.size());
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_last"}, rsp_last, 0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_req_ready"}, req_ready, 1);
   endtask

   initial begin
      bit ok;
      int unsigned guard;
      logic [15:0] old;
      logic        wr;
      logic [15:0] addr;

      #3;
      chk_reset_outputs("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // write then read back one word
      issue(1'b1, 16'h0010, 16'hBEEF, 4'd0);
      issue(1'b0, 16'h0010, 16'h0000, 4'd1);
      drain();

      // preload: 1..8 at 0x0000..0x000E, random elsewhere, plus the wrap region
      for (int i = 0; i < 8; i++) issue(1'b1, 16'(2 * i), 16'(i + 1), 4'd0);
      for (int i = 8; i < 32; i++) issue(1'b1, 16'(2 * i), 16'($urandom), 4'd0);
      issue(1'b1, 16'hFFFC, 16'hA55A, 4'd0);
      issue(1'b1, 16'hFFFE, 16'h5AA5, 4'd0);
      drain();

      // 8-beat burst back to back, then with stalls
      issue(1'b0, 16'h0000, 16'h0000, 4'd8);
      drain();
      rdy_mode = 2;
      pat = 0;
      issue(1'b0, 16'h0000, 16'h0000, 4'd8);
      drain();
      rdy_mode = 0;

      // rejects: misaligned read, oversize burst, misaligned write
      issue(1'b0, 16'h0003, 16'h0000, 4'd1);
      issue(1'b0, 16'h0000, 16'h0000, 4'd9);
      issue(1'b1, 16'h0011, 16'h1234, 4'd0);
      issue(1'b0, 16'h0010, 16'h0000, 4'd1);
      drain();

      // burst wrapping past the top of the address space
      issue(1'b0, 16'hFFFC, 16'h0000, 4'd4);
      drain();

      // randomized traffic
      for (int k = 0; k < 40; k++) begin
         rdy_mode = $urandom_range(0, 2);
         wr = 1'($urandom_range(0, 1));
         addr = wr ? 16'(2 * $urandom_range(0, 31)) : 16'(2 * $urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) addr[0] = 1'b1;
         issue(wr, addr, 16'($urandom), 4'($urandom_range(0, 12)));
      end
      drain();
      rdy_mode = 0;

      // reset while beat 3 of an 8-beat burst is presented
      @(posedge clk);
      #1 rdy_mode = 3;
      rsp_ready = 1'b0;
      issue(1'b0, 16'h0000, 16'h0000, 4'd8);
      guard = 0;
      do begin
         @(posedge clk);
         #1;
         guard++;
      end while (!rsp_valid && guard < 50);
      chk("burst_started", rsp_valid, 1);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk("beat3_remaining", exp_q.size(), 6);
      rst = 1'b1;
      #1;
      chk_reset_outputs("midburst_rst");
      exp_q.delete();
      idle_chk = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      rdy_mode = 0;

      // reset during WAIT of a write drops the write
      old = model[16];
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 16'h0020;
      req_wdata = ~old;
      req_len   = 4'd0;
      wait_accept(ok);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("wait_rst_busy", busy, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      issue(1'b0, 16'h0020, 16'h0000, 4'd1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
